// File: rtl/instruction_fetch_responder.sv
// Instruction-memory responder for the fetch stage: a program-loadable word memory
// read through a LATENCY-deep registered pipeline that honours stall and flush.
module instruction_fetch_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [INST_WIDTH-1:0] load_data,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instruction_pc,
    output logic                  valid,
    output logic                  fault
);

    localparam int                  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INST_WIDTH-1:0] data;
        logic                  fault;
    } stage_t;

    logic [INST_WIDTH-1:0] mem [DEPTH];
    stage_t                stages [LATENCY];

    logic                  pc_out_of_range;
    logic                  load_in_range;
    logic [INST_WIDTH-1:0] fetch_data;

    // Zero-extend both sides so a full-width pc never aliases into range.
    assign pc_out_of_range = ({1'b0, pc} >= DEPTH_LIMIT);
    assign load_in_range   = ({1'b0, load_addr} < DEPTH_LIMIT);
    assign fetch_data      = pc_out_of_range ? '0 : mem[pc[IDX_W-1:0]];

    // NOTE: the memory array has no reset so it maps onto RAM and keeps the loaded
    // program across a pipeline reset.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // NOTE: non-blocking assignments let every stage read its predecessor's old value,
    // which is what makes the shift and the read-before-write behaviour correct.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else if (!stall) begin
            if (flush) begin
                // Fault is cleared with valid so the output needs no gating logic.
                for (int i = 0; i < LATENCY; i++) begin
                    stages[i].valid <= 1'b0;
                    stages[i].fault <= 1'b0;
                end
            end else begin
                stages[0].valid <= 1'b1;
                stages[0].addr  <= pc;
                stages[0].data  <= fetch_data;
                stages[0].fault <= pc_out_of_range;
                for (int i = 1; i < LATENCY; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end
    end

    assign instruction    = stages[LATENCY-1].data;
    assign instruction_pc = stages[LATENCY-1].addr;
    assign valid          = stages[LATENCY-1].valid;
    assign fault          = stages[LATENCY-1].fault;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed bench for instruction_fetch_responder: a LATENCY=2 and a LATENCY=1 instance
// share one stimulus stream; expected outputs are hand-computed per scenario.
module tb_instruction_fetch_responder;

    localparam int AW = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          stall;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;

    logic [IW-1:0] inst2, inst1;
    logic [AW-1:0] ipc2, ipc1;
    logic          valid2, valid1, fault2, fault1;
    logic [49:0]   obs2, obs1;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [IW-1:0] B0 = 32'hB000_0000;
    localparam logic [IW-1:0] B1 = 32'hB111_1111;
    localparam logic [IW-1:0] W255 = 32'h0000_55AA;

    instruction_fetch_responder #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instruction(inst2), .instruction_pc(ipc2), .valid(valid2), .fault(fault2)
    );

    instruction_fetch_responder #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instruction(inst1), .instruction_pc(ipc1), .valid(valid1), .fault(fault1)
    );

    always #5 clk = ~clk;

    assign obs2 = {valid2, fault2, ipc2, inst2};
    assign obs1 = {valid1, fault1, ipc1, inst1};

    function automatic logic [IW-1:0] word(input int i);
        return 32'hA000_0000 + IW'(i);
    endfunction

    function automatic logic [49:0] pack(input logic v, input logic f, input logic [AW-1:0] p,
                                         input logic [IW-1:0] d);
        return {v, f, p, d};
    endfunction

    // When no valid is expected only valid and fault are defined.
    function automatic logic [49:0] msk(input logic v);
        return v ? '1 : {2'b11, 48'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse between edges; memory must survive it.
    task automatic restart();
        stall = 1'b0; flush = 1'b0; load_en = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #1;
        tests_run++;
        if (obs2 !== 50'h0) begin
            tests_failed++; $display("FAIL reset_l2: got %h want 0", obs2);
        end
        tests_run++;
        if (obs1 !== 50'h0) begin
            tests_failed++; $display("FAIL reset_l1: got %h want 0", obs1);
        end
        step(); step();
        tests_run++;
        if (obs2 !== 50'h0) begin
            tests_failed++; $display("FAIL reset_held: got %h want 0", obs2);
        end
        reset = 1'b1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = AW'(i); load_data = word(i);
            step();
        end
        load_addr = 16'd255; load_data = W255;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_basic();
        logic [49:0] e2, e1;
        restart();
        for (int e = 0; e < 5; e++) begin
            pc = AW'(e);
            step();
            e2 = pack(e > 0, 1'b0, AW'(e - 1), word(e - 1));
            e1 = pack(1'b1, 1'b0, AW'(e), word(e));
            tests_run++;
            if ((obs2 & msk(e > 0)) !== (e2 & msk(e > 0))) begin
                tests_failed++; $display("FAIL basic_l2[%0d]: got %h want %h", e, obs2 & msk(e > 0), e2 & msk(e > 0));
            end
            tests_run++;
            if (obs1 !== e1) begin
                tests_failed++; $display("FAIL basic_l1[%0d]: got %h want %h", e, obs1, e1);
            end
        end
    endtask

    task automatic test_stall();
        logic [49:0] e2, e1;
        restart();
        pc = 16'd0; step();
        pc = 16'd1; step();
        pc = 16'd2; step();
        e2 = pack(1'b1, 1'b0, 16'd1, word(1));
        e1 = pack(1'b1, 1'b0, 16'd2, word(2));
        stall = 1'b1; pc = 16'd3;
        for (int k = 0; k < 3; k++) begin
            flush = (k == 1);
            step();
            tests_run++;
            if (obs2 !== e2) begin
                tests_failed++; $display("FAIL stall_hold_l2[%0d]: got %h want %h", k, obs2, e2);
            end
            tests_run++;
            if (obs1 !== e1) begin
                tests_failed++; $display("FAIL stall_hold_l1[%0d]: got %h want %h", k, obs1, e1);
            end
        end
        stall = 1'b0; flush = 1'b0;
        for (int k = 2; k < 4; k++) begin
            pc = AW'(k + 1);
            step();
            e2 = pack(1'b1, 1'b0, AW'(k), word(k));
            tests_run++;
            if (obs2 !== e2) begin
                tests_failed++; $display("FAIL stall_resume[%0d]: got %h want %h", k, obs2, e2);
            end
        end
    endtask

    task automatic test_flush();
        logic [49:0] e2;
        restart();
        pc = 16'd0; step();
        pc = 16'd1; step();
        e2 = pack(1'b1, 1'b0, 16'd0, word(0));
        tests_run++;
        if (obs2 !== e2) begin
            tests_failed++; $display("FAIL flush_pre: got %h want %h", obs2, e2);
        end
        pc = 16'd2; flush = 1'b1; step();
        tests_run++;
        if ({valid2, fault2, valid1, fault1} !== 4'b0000) begin
            tests_failed++; $display("FAIL flush_edge: got %b want 0000", {valid2, fault2, valid1, fault1});
        end
        flush = 1'b0; pc = 16'd9; step();
        tests_run++;
        if ({valid2, fault2} !== 2'b00) begin
            tests_failed++; $display("FAIL flush_target_l2: got %b want 00", {valid2, fault2});
        end
        tests_run++;
        if (obs1 !== pack(1'b1, 1'b0, 16'd9, word(9))) begin
            tests_failed++; $display("FAIL flush_target_l1: got %h want %h", obs1, pack(1'b1, 1'b0, 16'd9, word(9)));
        end
        for (int k = 9; k < 11; k++) begin
            pc = AW'(k + 1);
            step();
            e2 = pack(1'b1, 1'b0, AW'(k), word(k));
            tests_run++;
            if (obs2 !== e2) begin
                tests_failed++; $display("FAIL flush_post[%0d]: got %h want %h", k, obs2, e2);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] pcs  [6] = '{16'd300, 16'd255, 16'd256, 16'hFFFF, 16'd5, 16'd6};
        logic [IW-1:0] data [6] = '{32'h0, W255, 32'h0, 32'h0, word(5), word(6)};
        logic          flt  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [49:0]   e2;
        restart();
        for (int k = 0; k < 6; k++) begin
            pc = pcs[k];
            step();
            if (k == 0) begin
                tests_run++;
                if ({valid2, fault2} !== 2'b00) begin
                    tests_failed++; $display("FAIL oor_idle: got %b want 00", {valid2, fault2});
                end
            end else begin
                e2 = pack(1'b1, flt[k-1], pcs[k-1], data[k-1]);
                tests_run++;
                if (obs2 !== e2) begin
                    tests_failed++; $display("FAIL oor[%0d]: got %h want %h", k - 1, obs2, e2);
                end
            end
            tests_run++;
            if (obs1 !== pack(1'b1, flt[k], pcs[k], data[k])) begin
                tests_failed++; $display("FAIL oor_l1[%0d]: got %h want %h", k, obs1, pack(1'b1, flt[k], pcs[k], data[k]));
            end
        end
    endtask

    task automatic test_load_bypass();
        logic [49:0] e2;
        restart();
        pc = 16'd0; load_en = 1'b1; load_addr = 16'd7; load_data = B0; step();
        pc = 16'd7; load_data = B1; step();
        tests_run++;
        if (obs1 !== pack(1'b1, 1'b0, 16'd7, B0)) begin
            tests_failed++; $display("FAIL rbw_l1_old: got %h want %h", obs1, pack(1'b1, 1'b0, 16'd7, B0));
        end
        pc = 16'd7; load_addr = 16'd259; load_data = 32'hDEAD_BEEF; step();
        e2 = pack(1'b1, 1'b0, 16'd7, B0);
        tests_run++;
        if (obs2 !== e2) begin
            tests_failed++; $display("FAIL rbw_old: got %h want %h", obs2, e2);
        end
        tests_run++;
        if (obs1 !== pack(1'b1, 1'b0, 16'd7, B1)) begin
            tests_failed++; $display("FAIL rbw_l1_new: got %h want %h", obs1, pack(1'b1, 1'b0, 16'd7, B1));
        end
        load_en = 1'b0; pc = 16'd3; step();
        e2 = pack(1'b1, 1'b0, 16'd7, B1);
        tests_run++;
        if (obs2 !== e2) begin
            tests_failed++; $display("FAIL rbw_new: got %h want %h", obs2, e2);
        end
        step();
        e2 = pack(1'b1, 1'b0, 16'd3, word(3));
        tests_run++;
        if (obs2 !== e2) begin
            tests_failed++; $display("FAIL load_oor_ignored: got %h want %h", obs2, e2);
        end
    endtask

    task automatic test_reset_mid();
        logic [49:0] e2;
        restart();
        pc = 16'd4; step();
        pc = 16'd5; step();
        pc = 16'd6;
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({obs2, obs1} !== 100'h0) begin
            tests_failed++; $display("FAIL reset_mid: got %h %h want 0 0", obs2, obs1);
        end
        #1;
        reset = 1'b1;
        pc = 16'd0; step();
        tests_run++;
        if ({valid2, fault2} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_mid_l2_first: got %b want 00", {valid2, fault2});
        end
        tests_run++;
        if (obs1 !== pack(1'b1, 1'b0, 16'd0, word(0))) begin
            tests_failed++; $display("FAIL reset_mid_l1: got %h want %h", obs1, pack(1'b1, 1'b0, 16'd0, word(0)));
        end
        pc = 16'd1; step();
        e2 = pack(1'b1, 1'b0, 16'd0, word(0));
        tests_run++;
        if (obs2 !== e2) begin
            tests_failed++; $display("FAIL reset_mid_l2: got %h want %h", obs2, e2);
        end
    endtask

    initial begin
        test_reset();
        load_program();
        test_basic();
        test_stall();
        test_flush();
        test_out_of_range();
        test_load_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
